cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Round-robin arbiter that shares the single Common Data Bus among the functional units fed by the issue queues in the Tomasulo core. Each cycle it grants at most one completing unit, then broadcasts that unit's destination tag and result on a registered CDB. Issue-queue and reservation-station wakeup logic and the ROB consume the broadcast one cycle after the grant.

## Interface
- NUM_REQ, 4: number of requesting functional units; legal range is 2 to 8.
- TAG_WIDTH, 5: physical-register tag width; matches REG_ADDR_WIDTH.
- DATA_WIDTH, 32: result width.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset, synchronous and active-low.
- flush  input  1  branch-mispredict squash; suppresses grants and kills the pending broadcast.
- req_valid  input  NUM_REQ  bit i means unit i has a completed result.
- req_tag  input  NUM_REQ*TAG_WIDTH  packed; unit i occupies bits [i*TAG_WIDTH +: TAG_WIDTH].
- req_data  input  NUM_REQ*DATA_WIDTH  packed the same way.
- req_grant  output  NUM_REQ  one-hot or zero, combinational; unit i's result is taken this cycle.
- cdb_valid  output  1  registered broadcast valid.
- cdb_tag  output  TAG_WIDTH  registered broadcast tag.
- cdb_data  output  DATA_WIDTH  registered broadcast data.
- rr_ptr  output  max(1,$clog2(NUM_REQ))  current highest-priority requester; exposed for debug and verification.

## Operation
- Handshake: valid/grant.
  - A unit holds req_valid, tag and data stable until it sees req_grant[i]=1 at a rising edge.
  - On that edge the unit may present a new result or drop valid.
  - A unit may not withdraw req_valid before it is granted, except on flush.
- Search order: rr_ptr, rr_ptr+1, ... wrapping modulo NUM_REQ. The first requester with req_valid=1 wins.
- Pointer update on a grant to winner w: rr_ptr <= (w+1) mod NUM_REQ. This wraps correctly when NUM_REQ is not a power of two.
- With no grant, or with flush=1, rr_ptr holds its value.
- Broadcast register:
  - On a grant: cdb_valid<=1, cdb_tag<=req_tag[w], cdb_data<=req_data[w].
  - With no grant: cdb_valid<=0, and cdb_tag/cdb_data hold their previous values.
- Flush:
  - While flush=1, req_grant=0 combinationally.
  - cdb_valid<=0 at the same edge, so a broadcast registered in the prior cycle is still visible during the flush cycle and then dropped.
  - Requesters clear their own req_valid.
- Tag 0 is an ordinary tag and is broadcast like any other.
- Fairness: a continuously requesting unit is granted within NUM_REQ cycles of asserting valid, in the absence of flush.

## Timing
- Reset (reset=0 at a rising edge):
  - rr_ptr=0, cdb_valid=0, cdb_tag=0, cdb_data=0.
  - req_grant=0 while reset is low, regardless of req_valid.
  - Reset overrides flush.
- Latency: grant in cycle N, broadcast visible in cycle N+1. Throughput is one broadcast per cycle.
- req_grant depends only on req_valid, rr_ptr, flush and reset; it has no path from req_tag or req_data.
- Simultaneous requests: exactly one grant is issued; the losers keep valid and are reconsidered next cycle against the advanced pointer.
- Back-to-back: the same unit can win in consecutive cycles only if no other unit is requesting.
- Reset asserted mid-stream: any pending broadcast is lost (cdb_valid=0 the next cycle). Requesters are reset by the same signal.
- No state besides rr_ptr and the broadcast register.

## Test plan
- Reset then idle:
  - Check cdb_valid=0, cdb_tag=0, cdb_data=0, rr_ptr=0 and req_grant=0 on every cycle.
  - Hold reset low while req_valid=4'b1111 and confirm no grant.
- Single requester: unit 2 presents tag 5'b00011, data 32'h0000_00AA.
  - req_grant=4'b0100 in the same cycle.
  - Next cycle: cdb_valid=1, cdb_tag=3, cdb_data=32'hAA, rr_ptr=3.
- All four request continuously from rr_ptr=0 with tags 1, 2, 3, 4.
  - Grants are 0001, 0010, 0100, 1000, 0001.
  - Broadcast tags lag by one cycle: 1, 2, 3, 4, 1.
  - rr_ptr wraps from 3 to 0.
- Fairness with rr_ptr=1: unit 0 requests every cycle and unit 3 requests once.
  - Unit 3 is granted first.
  - Unit 0 is granted in the next cycle, not starved.
- Flush: grant unit 1 (tag 7) in cycle N and assert flush in cycle N+1 with req_valid=4'b1100.
  - In N+1: cdb_valid=1, cdb_tag=7, req_grant=0.
  - In N+2: cdb_valid=0, with rr_ptr unchanged at 2.
- NUM_REQ=3 build: three requesters always valid.
  - Grant order is 0, 1, 2, 0.
  - rr_ptr never takes the value 3.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the Common Data Bus. Picks at most one completing
// functional unit per cycle and broadcasts its tag/result one cycle later.
module cdb_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int TAG_WIDTH  = 5,
  parameter  int DATA_WIDTH = 32,
  localparam int PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]    req_tag,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_grant,
  output logic                            cdb_valid,
  output logic [TAG_WIDTH-1:0]            cdb_tag,
  output logic [DATA_WIDTH-1:0]           cdb_data,
  output logic [PTR_W-1:0]                rr_ptr
);

  // Wrap constants sized to the pointer so the modulo search stays width-clean.
  localparam logic [PTR_W:0]   NREQ = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

  logic [TAG_WIDTH-1:0]  tag_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [PTR_W-1:0]      win;
  logic                  any_grant;

  // Unpack the flat request buses into per-unit views.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign tag_arr[i]  = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
    assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Rotating priority search starting at rr_ptr; only valid/ptr/flush/reset
  // feed the grant so there is no path from tag or data.
  always_comb begin
    logic [PTR_W:0] idx;
    idx       = '0;
    win       = '0;
    any_grant = 1'b0;
    req_grant = '0;
    if (reset && !flush) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
        if (idx >= NREQ) idx = idx - NREQ;
        if (!any_grant && req_valid[idx[PTR_W-1:0]]) begin
          any_grant = 1'b1;
          win       = idx[PTR_W-1:0];
        end
      end
    end
    if (any_grant) req_grant[win] = 1'b1;
  end

  // Broadcast register and pointer advance; tag/data keep their last value
  // when idle so the bus does not toggle needlessly.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
    end else begin
      cdb_valid <= any_grant;
      if (any_grant) begin
        cdb_tag  <= tag_arr[win];
        cdb_data <= data_arr[win];
        rr_ptr   <= (win == LAST) ? '0 : win + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed literal cases plus a
// randomized handshake-following stream checked every cycle against a model.
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int TW = 5;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              reset, flush;
  logic [N-1:0]      req_valid;
  logic [N*TW-1:0]   req_tag;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_grant;
  logic              cdb_valid;
  logic [TW-1:0]     cdb_tag;
  logic [DW-1:0]     cdb_data;
  logic [1:0]        rr_ptr;

  // three-requester build
  logic              r3;
  logic [2:0]        v3;
  logic [3*TW-1:0]   t3;
  logic [3*DW-1:0]   d3;
  logic [2:0]        g3;
  logic              cv3;
  logic [TW-1:0]     ct3;
  logic [DW-1:0]     cd3;
  logic [1:0]        rr3;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  int           m_ptr = 0;
  logic         m_cv  = 1'b0;
  logic [TW-1:0] m_ct = '0;
  logic [DW-1:0] m_cd = '0;
  logic [N-1:0] g_last = '0;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(N), .TAG_WIDTH(TW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .req_valid(req_valid),
    .req_tag(req_tag), .req_data(req_data), .req_grant(req_grant),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .rr_ptr(rr_ptr));

  cdb_arbiter #(.NUM_REQ(3), .TAG_WIDTH(TW), .DATA_WIDTH(DW)) u3 (
    .clk(clk), .reset(r3), .flush(1'b0), .req_valid(v3),
    .req_tag(t3), .req_data(d3), .req_grant(g3),
    .cdb_valid(cv3), .cdb_tag(ct3), .cdb_data(cd3), .rr_ptr(rr3));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int u, input logic [TW-1:0] t, input logic [DW-1:0] d);
    req_tag[u*TW +: TW] = t;
    req_data[u*DW +: DW] = d;
  endtask

  // Model-vs-DUT comparison at every falling edge; model then advances to
  // the state it must hold after the next rising edge.
  initial begin
    int w;
    logic [N-1:0] eg;
    @(posedge clk);
    forever begin
      @(negedge clk);
      eg = '0;
      w  = 0;
      if (reset && !flush) begin
        for (int k = 0; k < N; k++) begin
          int u;
          u = (m_ptr + k) % N;
          if (eg == '0 && req_valid[u]) begin
            eg[u] = 1'b1;
            w = u;
          end
        end
      end
      chk("grant", 64'(req_grant), 64'(eg));
      chk("cdb_valid", 64'(cdb_valid), 64'(m_cv));
      chk("cdb_tag", 64'(cdb_tag), 64'(m_ct));
      chk("cdb_data", 64'(cdb_data), 64'(m_cd));
      chk("rr_ptr", 64'(rr_ptr), 64'(m_ptr));
      g_last = eg;
      if (!reset) begin
        m_ptr = 0; m_cv = 1'b0; m_ct = '0; m_cd = '0;
      end else if (eg != '0) begin
        m_cv  = 1'b1;
        m_ct  = req_tag[w*TW +: TW];
        m_cd  = req_data[w*DW +: DW];
        m_ptr = (w + 1) % N;
      end else begin
        m_cv = 1'b0;
      end
    end
  end

  // Stimulus: directed cases with literal expectations, then random traffic.
  initial begin
    logic [N-1:0] exp_g [5];
    logic [2:0]   exp_g3 [4];
    exp_g  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_g3 = '{3'b001, 3'b010, 3'b100, 3'b001};
    reset = 1'b0; flush = 1'b0; req_valid = '0; req_tag = '0; req_data = '0;
    r3 = 1'b0; v3 = 3'b111; t3 = '0; d3 = '0;

    // reset then idle, then reset held with all requesting
    repeat (3) cyc();
    req_valid = 4'b1111;
    #1;
    chk("rst_grant", 64'(req_grant), 64'h0);
    chk("rst_cdb_valid", 64'(cdb_valid), 64'h0);
    chk("rst_cdb_tag", 64'(cdb_tag), 64'h0);
    chk("rst_cdb_data", 64'(cdb_data), 64'h0);
    chk("rst_rr_ptr", 64'(rr_ptr), 64'h0);
    cyc(); #1;
    chk("rst_hold_grant", 64'(req_grant), 64'h0);

    // single requester
    cyc();
    reset = 1'b1; req_valid = 4'b0100; set_req(2, 5'd3, 32'h0000_00AA);
    #1;
    chk("single_grant", 64'(req_grant), 64'h4);
    cyc();
    req_valid = '0;
    #1;
    chk("single_cdb_valid", 64'(cdb_valid), 64'h1);
    chk("single_cdb_tag", 64'(cdb_tag), 64'h3);
    chk("single_cdb_data", 64'(cdb_data), 64'hAA);
    chk("single_rr_ptr", 64'(rr_ptr), 64'h3);

    // walk pointer to 0 via unit 3
    req_valid = 4'b1000; set_req(3, 5'd9, 32'h9);
    cyc();
    for (int i = 0; i < N; i++) set_req(i, TW'(i + 1), DW'(32'h100 + i));
    req_valid = 4'b1111;
    #1;
    chk("all_rr_start", 64'(rr_ptr), 64'h0);
    for (int k = 0; k < 5; k++) begin
      chk("all_grant", 64'(req_grant), 64'(exp_g[k]));
      if (k > 0) chk("all_cdb_tag", 64'(cdb_tag), 64'(k));
      cyc(); #1;
    end
    chk("all_cdb_tag_wrap", 64'(cdb_tag), 64'h1);
    chk("all_rr_end", 64'(rr_ptr), 64'h1);

    // fairness from rr_ptr=1: unit 3 once, unit 0 always
    req_valid = 4'b1001;
    #1;
    chk("fair_first", 64'(req_grant), 64'h8);
    cyc();
    req_valid = 4'b0001;
    #1;
    chk("fair_second", 64'(req_grant), 64'h1);
    chk("fair_rr", 64'(rr_ptr), 64'h0);
    cyc();
    req_valid = '0;
    #1;
    chk("fair_rr_after", 64'(rr_ptr), 64'h1);

    // flush kills grant and the pending broadcast
    req_valid = 4'b0010; set_req(1, 5'd7, 32'h77);
    #1;
    chk("flush_pre_grant", 64'(req_grant), 64'h2);
    cyc();
    flush = 1'b1; req_valid = 4'b1100;
    #1;
    chk("flush_grant", 64'(req_grant), 64'h0);
    chk("flush_cdb_valid", 64'(cdb_valid), 64'h1);
    chk("flush_cdb_tag", 64'(cdb_tag), 64'h7);
    cyc();
    flush = 1'b0; req_valid = '0;
    #1;
    chk("flush_after_valid", 64'(cdb_valid), 64'h0);
    chk("flush_after_rr", 64'(rr_ptr), 64'h2);

    // three-requester build, all always valid
    r3 = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("n3_grant", 64'(g3), 64'(exp_g3[k]));
      chk("n3_rr", 64'(rr3), 64'(k % 3));
      if (rr3 == 2'd3) chk("n3_rr_not3", 64'(rr3), 64'h0);
      cyc(); #1;
    end

    // random traffic obeying the valid/grant handshake
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (!reset || flush) begin
        req_valid = '0;
      end else begin
        for (int i = 0; i < N; i++)
          if (req_valid[i] && g_last[i] && $urandom_range(0, 1) == 0)
            req_valid[i] = 1'b0;
          else if (req_valid[i] && g_last[i])
            set_req(i, TW'($urandom), DW'($urandom));
      end
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 99) < 40) begin
          set_req(i, TW'($urandom), DW'($urandom));
          req_valid[i] = 1'b1;
        end
      flush = ($urandom_range(0, 99) < 5);
      reset = !($urandom_range(0, 199) < 2);
    end
    cyc();
    reset = 1'b1; flush = 1'b0; req_valid = '0;
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
